multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter RESET_PC, 32'h28, PC value loaded on reset.
REQ-002 Parameter MAX_INSTR, 43, count of retired instructions after which the block halts.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  leaves IDLE when high in IDLE.
REQ-006 ins  input  32  instruction word from fetch stage for the current PC.
REQ-007 zero  input  1  ALU zero flag from execute stage.
REQ-008 imm  input  32  sign-extended immediate from decode.
REQ-009 jTarget  input  32  jump offset from decode.
REQ-010 PCin  output  32  registered program counter driven to fetch.
REQ-011 RegWrite, ALUSrc, Mem2Reg, MemRead, MemWrite, Link  output  1 each  datapath controls.
REQ-012 op  output  3  ALU operation select.
REQ-013 state  output  3  current FSM state encoding.
REQ-014 retired  output  16  retired-instruction counter.
REQ-015 done  output  1  high while in HALT after MAX_INSTR retirements.
REQ-016 illegal  output  1  sticky flag for an unsupported opcode.

Function
REQ-017 States SHALL be IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6; code 7 SHALL return to IDLE on the next edge.
REQ-018 IDLE->FETCH on start=1; otherwise the block SHALL stay in IDLE with all controls 0.
REQ-019 FETCH->DECODE unconditionally; on this edge the block SHALL latch ins[6:0] into an internal opcode register, and all later states SHALL decode the latched opcode, not live ins.
REQ-020 DECODE->EXEC for opcodes 7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F; any other opcode SHALL set illegal=1 and go to HALT.
REQ-021 EXEC outputs by opcode: 7'h33: ALUSrc=0, op=3'b010; 7'h13/7'h03/7'h23: ALUSrc=1, op=3'b010; 7'h63: ALUSrc=0, op=3'b110; 7'h6F: ALUSrc=1, op=3'b010.
REQ-022 EXEC next state: 7'h03/7'h23 -> MEM; 7'h33/7'h13/7'h6F -> WB; 7'h63 -> FETCH, with retirement.
REQ-023 MEM SHALL hold the EXEC ALUSrc/op values; 7'h03 asserts MemRead=1 and goes to WB; 7'h23 asserts MemWrite=1 and goes to FETCH, with retirement.
REQ-024 WB SHALL assert RegWrite=1 for exactly one cycle, with Mem2Reg=1 for 7'h03 only and Link=1 for 7'h6F only; WB->FETCH, with retirement.
REQ-025 All control outputs SHALL be combinational functions of state and the latched opcode; every control not named for a state SHALL be 0, and MemWrite and RegWrite SHALL never both be high.
REQ-026 Retirement is the edge leaving the last state of an instruction; on it PCin SHALL update: 7'h63 with zero=1 -> PCin+(imm<<1); 7'h6F -> PCin+(jTarget<<2); otherwise PCin+4. All arithmetic is 32-bit modulo 2^32 and wraps silently.
REQ-027 The branch decision SHALL sample zero on the EXEC->FETCH edge.
REQ-028 retired SHALL increment by 1 on each retirement; when the incremented value equals MAX_INSTR the next state SHALL be HALT instead of FETCH.
REQ-029 HALT SHALL be absorbing until reset, with done=1, all controls 0, and PCin and retired frozen; start SHALL be ignored in HALT.
REQ-030 The fetch-to-retire latency SHALL be 4 cycles for branch, 5 for R-type, I-ALU, jal and store, and 6 for load.

Reset
REQ-031 With reset=1 at a rising edge: state=IDLE, PCin=RESET_PC, retired=0, done=0, illegal=0, opcode register=0.
REQ-032 Reset SHALL take priority over every transition, including mid-instruction (e.g. in MEM), and SHALL discard any pending PC update or retirement.
REQ-033 Outputs SHALL be defined (all controls 0) in the cycle after reset deasserts.

Verification
REQ-034 Reset, start=1, ins=add (opcode 33): states 1,2,3,5,1; RegWrite=1 only in WB; PCin 0x28->0x2C; retired=1.
REQ-035 Load (opcode 03): MemRead=1 in MEM, Mem2Reg=1 and RegWrite=1 in WB; store (opcode 23): MemWrite=1 in MEM, no WB visit, PC+4.
REQ-036 beq with imm=8 at PC=0x30: zero=1 -> PCin=0x40; zero=0 -> PCin=0x34; RegWrite and MemWrite 0 throughout.
REQ-037 jal with jTarget=3 at PC=0x2C: Link=1 and RegWrite=1 in WB; PCin=0x38.
REQ-038 Opcode 7'h7F in DECODE -> illegal=1, state=6, PCin unchanged; 43 consecutive adds -> done=1 with retired=43, PCin=0x28+43*4=0xD4.
REQ-039 Reset asserted during MEM of a store -> MemWrite low the next cycle, PCin=0x28, retired=0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multicycle controller: sequences fetch/decode/execute/memory/writeback for a
// small RV-like opcode subset, drives datapath controls and tracks the PC.
module multicycle_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h28,
  parameter int unsigned MAX_INSTR = 43
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] ins,
  input  logic        zero,
  input  logic [31:0] imm,
  input  logic [31:0] jTarget,
  output logic [31:0] PCin,
  output logic        RegWrite,
  output logic        ALUSrc,
  output logic        Mem2Reg,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        Link,
  output logic [2:0]  op,
  output logic [2:0]  state,
  output logic [15:0] retired,
  output logic        done,
  output logic        illegal
);

  localparam int unsigned SW = 3;
  localparam int unsigned OW = 7;
  localparam int unsigned CW = 16;

  localparam logic [SW-1:0] S_IDLE   = 3'd0;
  localparam logic [SW-1:0] S_FETCH  = 3'd1;
  localparam logic [SW-1:0] S_DECODE = 3'd2;
  localparam logic [SW-1:0] S_EXEC   = 3'd3;
  localparam logic [SW-1:0] S_MEM    = 3'd4;
  localparam logic [SW-1:0] S_WB     = 3'd5;
  localparam logic [SW-1:0] S_HALT   = 3'd6;

  localparam logic [OW-1:0] OP_R   = 7'h33;
  localparam logic [OW-1:0] OP_I   = 7'h13;
  localparam logic [OW-1:0] OP_LD  = 7'h03;
  localparam logic [OW-1:0] OP_ST  = 7'h23;
  localparam logic [OW-1:0] OP_BR  = 7'h63;
  localparam logic [OW-1:0] OP_JAL = 7'h6F;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;

  logic [OW-1:0] opcode;
  logic [SW-1:0] state_next;
  logic          retire;
  logic          illegal_set;
  logic          legal;
  logic [CW-1:0] retired_inc;
  logic          hit_max;
  logic [31:0]   pc_next;

  // Upper instruction bits are decoded elsewhere in the datapath.
  logic unused_ins;
  assign unused_ins = &{1'b0, ins[31:OW]};

  assign retired_inc = retired + CW'(1);
  assign hit_max     = (retired_inc == CW'(MAX_INSTR));

  assign legal = (opcode == OP_R)  || (opcode == OP_I)  || (opcode == OP_LD) ||
                 (opcode == OP_ST) || (opcode == OP_BR) || (opcode == OP_JAL);

  // PC target on retirement; zero is only consulted on the EXEC->FETCH edge.
  always_comb begin
    pc_next = PCin + 32'd4;
    if (opcode == OP_BR && zero) begin
      pc_next = PCin + (imm << 1);
    end else if (opcode == OP_JAL) begin
      pc_next = PCin + (jTarget << 2);
    end
  end

  // Next state and datapath controls, all decoded from the latched opcode.
  always_comb begin
    state_next  = state;
    retire      = 1'b0;
    illegal_set = 1'b0;
    RegWrite    = 1'b0;
    ALUSrc      = 1'b0;
    Mem2Reg     = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    Link        = 1'b0;
    op          = 3'b000;

    if (state == S_EXEC || state == S_MEM) begin
      case (opcode)
        OP_R:                      begin ALUSrc = 1'b0; op = ALU_ADD; end
        OP_I, OP_LD, OP_ST, OP_JAL: begin ALUSrc = 1'b1; op = ALU_ADD; end
        OP_BR:                     begin ALUSrc = 1'b0; op = ALU_SUB; end
        default:                   begin ALUSrc = 1'b0; op = 3'b000; end
      endcase
    end

    case (state)
      S_IDLE: begin
        if (start) state_next = S_FETCH;
      end
      S_FETCH: begin
        state_next = S_DECODE;
      end
      S_DECODE: begin
        if (legal) begin
          state_next = S_EXEC;
        end else begin
          state_next  = S_HALT;
          illegal_set = 1'b1;
        end
      end
      S_EXEC: begin
        case (opcode)
          OP_LD, OP_ST:        state_next = S_MEM;
          OP_R, OP_I, OP_JAL:  state_next = S_WB;
          OP_BR:               retire = 1'b1;
          default:             state_next = S_IDLE;
        endcase
      end
      S_MEM: begin
        case (opcode)
          OP_LD: begin
            MemRead    = 1'b1;
            state_next = S_WB;
          end
          OP_ST: begin
            MemWrite = 1'b1;
            retire   = 1'b1;
          end
          default: state_next = S_IDLE;
        endcase
      end
      S_WB: begin
        RegWrite = 1'b1;
        Mem2Reg  = (opcode == OP_LD);
        Link     = (opcode == OP_JAL);
        retire   = 1'b1;
      end
      S_HALT: begin
        state_next = S_HALT;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    if (retire) state_next = hit_max ? S_HALT : S_FETCH;
  end

  // State, opcode latch, PC and retirement bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      opcode  <= '0;
      PCin    <= RESET_PC;
      retired <= '0;
      done    <= 1'b0;
      illegal <= 1'b0;
    end else begin
      state <= state_next;
      if (state == S_FETCH) opcode <= ins[OW-1:0];
      if (retire) begin
        PCin    <= pc_next;
        retired <= retired_inc;
        if (hit_max) done <= 1'b1;
      end
      if (illegal_set) illegal <= 1'b1;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each opcode class through the FSM
// and checks controls, PC, retirement, halt and reset behaviour.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] ins;
  logic        zero;
  logic [31:0] imm;
  logic [31:0] jTarget;
  logic [31:0] PCin;
  logic        RegWrite, ALUSrc, Mem2Reg, MemRead, MemWrite, Link;
  logic [2:0]  op;
  logic [2:0]  state;
  logic [15:0] retired;
  logic        done;
  logic        illegal;

  int checks = 0;
  int errors = 0;

  // {RegWrite, ALUSrc, Mem2Reg, MemRead, MemWrite, Link, op}
  logic [8:0] ctrl;
  assign ctrl = {RegWrite, ALUSrc, Mem2Reg, MemRead, MemWrite, Link, op};

  multicycle_ctrl #(.RESET_PC(32'h28), .MAX_INSTR(43)) dut (
    .clk(clk), .reset(reset), .start(start), .ins(ins), .zero(zero),
    .imm(imm), .jTarget(jTarget), .PCin(PCin), .RegWrite(RegWrite),
    .ALUSrc(ALUSrc), .Mem2Reg(Mem2Reg), .MemRead(MemRead),
    .MemWrite(MemWrite), .Link(Link), .op(op), .state(state),
    .retired(retired), .done(done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; zero = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  // Runs one instruction from a sampled FETCH until FETCH or HALT is reached.
  task automatic run_instr(input logic [6:0] opc, input logic z);
    bit ended = 0;
    ins  = {25'h0, opc};
    zero = 1'b0;
    step();
    for (int i = 0; i < 8 && !ended; i++) begin
      if (state == 3'd3) zero = z;
      step();
      if (state == 3'd1 || state == 3'd6) ended = 1;
    end
    zero = 1'b0;
    if (!ended) chk("run_instr_timeout", 32'(state), 32'd1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; ins = 32'h0; zero = 1'b0;
    imm = 32'h0; jTarget = 32'h0;

    // Reset state
    do_reset();
    reset = 1'b1;
    step();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_pc", PCin, 32'h28);
    chk("rst_retired", 32'(retired), 32'd0);
    chk("rst_flags", {30'h0, done, illegal}, 32'd0);
    reset = 1'b0;
    step();
    chk("post_rst_ctrl", 32'(ctrl), 32'h000);
    chk("idle_hold", 32'(state), 32'd0);

    // add: 1,2,3,5,1 with live ins changed after the opcode is latched
    ins = 32'h0020_8033; start = 1'b1;
    step();
    chk("add_fetch", 32'(state), 32'd1);
    start = 1'b0;
    step();
    chk("add_decode", 32'(state), 32'd2);
    ins = 32'h0000_007F;
    step();
    chk("add_exec", 32'(state), 32'd3);
    chk("add_exec_ctrl", 32'(ctrl), 32'h002);
    step();
    chk("add_wb", 32'(state), 32'd5);
    chk("add_wb_ctrl", 32'(ctrl), 32'h100);
    chk("add_wb_pc", PCin, 32'h28);
    step();
    chk("add_ret_state", 32'(state), 32'd1);
    chk("add_ret_pc", PCin, 32'h2C);
    chk("add_ret_cnt", 32'(retired), 32'd1);
    chk("add_ret_ctrl", 32'(ctrl), 32'h000);

    // jal jTarget=3 at 0x2C -> 0x38
    ins = 32'h0000_006F; jTarget = 32'd3;
    step();
    step();
    chk("jal_exec_ctrl", 32'(ctrl), 32'h082);
    step();
    chk("jal_wb", 32'(state), 32'd5);
    chk("jal_wb_ctrl", 32'(ctrl), 32'h108);
    step();
    chk("jal_pc", PCin, 32'h38);
    chk("jal_cnt", 32'(retired), 32'd2);

    // load at 0x38
    ins = 32'h0000_0003;
    step();
    step();
    chk("ld_exec_ctrl", 32'(ctrl), 32'h082);
    step();
    chk("ld_mem", 32'(state), 32'd4);
    chk("ld_mem_ctrl", 32'(ctrl), 32'h0A2);
    step();
    chk("ld_wb", 32'(state), 32'd5);
    chk("ld_wb_ctrl", 32'(ctrl), 32'h140);
    step();
    chk("ld_pc", PCin, 32'h3C);

    // store at 0x3C: MEM then straight back to FETCH
    ins = 32'h0000_0023;
    step();
    step();
    step();
    chk("st_mem", 32'(state), 32'd4);
    chk("st_mem_ctrl", 32'(ctrl), 32'h092);
    step();
    chk("st_no_wb", 32'(state), 32'd1);
    chk("st_pc", PCin, 32'h40);
    chk("st_cnt", 32'(retired), 32'd4);

    // jal with negative offset wraps modulo 2^32: 0x40 + 0xFFFFFFFC = 0x3C
    jTarget = 32'hFFFF_FFFF;
    run_instr(7'h6F, 1'b0);
    chk("jal_wrap_pc", PCin, 32'h3C);

    // beq taken at 0x30, zero only raised in EXEC
    do_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    run_instr(7'h33, 1'b0);
    run_instr(7'h33, 1'b0);
    chk("beq_start_pc", PCin, 32'h30);
    imm = 32'd8; ins = 32'h0000_0063;
    step();
    step();
    chk("beq_exec_ctrl", 32'(ctrl), 32'h006);
    zero = 1'b1;
    step();
    zero = 1'b0;
    chk("beq_t_state", 32'(state), 32'd1);
    chk("beq_t_pc", PCin, 32'h40);

    // beq not taken at 0x30
    do_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    run_instr(7'h33, 1'b0);
    run_instr(7'h33, 1'b0);
    run_instr(7'h63, 1'b0);
    chk("beq_nt_pc", PCin, 32'h34);
    chk("beq_nt_cnt", 32'(retired), 32'd3);

    // Reset during store MEM discards the retirement
    do_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    ins = 32'h0000_0023;
    step();
    step();
    step();
    chk("rst_mem_state", 32'(state), 32'd4);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_mem_memw", 32'(MemWrite), 32'd0);
    chk("rst_mem_st", 32'(state), 32'd0);
    chk("rst_mem_pc", PCin, 32'h28);
    chk("rst_mem_cnt", 32'(retired), 32'd0);

    // Illegal opcode halts in DECODE with PC unchanged; start ignored
    do_reset();
    start = 1'b1; ins = 32'h0000_007F;
    step();
    start = 1'b0;
    step();
    step();
    chk("ill_state", 32'(state), 32'd6);
    chk("ill_flag", 32'(illegal), 32'd1);
    chk("ill_pc", PCin, 32'h28);
    chk("ill_ctrl", 32'(ctrl), 32'h000);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("ill_absorb", 32'(state), 32'd6);

    // 43 adds reach HALT with done
    do_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int n = 0; n < 43; n++) run_instr(7'h33, 1'b0);
    chk("max_state", 32'(state), 32'd6);
    chk("max_done", 32'(done), 32'd1);
    chk("max_cnt", 32'(retired), 32'd43);
    chk("max_pc", PCin, 32'hD4);
    chk("max_illegal", 32'(illegal), 32'd0);
    start = 1'b1;
    step();
    step();
    start = 1'b0;
    chk("halt_frozen_pc", PCin, 32'hD4);
    chk("halt_frozen_cnt", 32'(retired), 32'd43);
    chk("halt_ctrl", 32'(ctrl), 32'h000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
